// File: rtl/ps2_kbd_if.sv
// Bus between the PS/2 receiver / CPU side and the keyboard controller.
// The master drives frames and register strobes; the slave returns KBSR/KBDR/IRQ.
interface ps2_kbd_if;
  logic        cmd_rdy;
  logic [8:0]  cmd;
  logic        error;
  logic        kbsr_rd;
  logic        kbsr_wr;
  logic [15:0] kbsr_wdata;
  logic        kbdr_rd;
  logic [15:0] kbsr;
  logic [15:0] kbdr;
  logic        kbd_irq;

  modport master (
    output cmd_rdy, cmd, error, kbsr_rd, kbsr_wr, kbsr_wdata, kbdr_rd,
    input  kbsr, kbdr, kbd_irq
  );

  modport slave (
    input  cmd_rdy, cmd, error, kbsr_rd, kbsr_wr, kbsr_wdata, kbdr_rd,
    output kbsr, kbdr, kbd_irq
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: folds E0/F0 prefixes into key events, queues them
// in a small FIFO and presents them through LC-3 style KBSR/KBDR registers.
module ps2_kbd_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  ps2_kbd_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} pfx_state_e;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } kbd_event_t;

  localparam logic [7:0]     CODE_EXT = 8'hE0;
  localparam logic [7:0]     CODE_BRK = 8'hF0;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  pfx_state_e       state_q, state_d;
  kbd_event_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ie_q, ie_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       errcnt_q, errcnt_d;
  logic [15:0]      kbsr_q, kbsr_d;
  logic [15:0]      kbdr_q, kbdr_d;
  logic             irq_q, irq_d;

  logic       ok_frame, err_frame, wr_clr;
  logic       push_req, push_ok, pop, full;
  logic [7:0] scan;
  kbd_event_t push_evt, head_d;

  assign scan      = bus.cmd[7:0];
  assign ok_frame  = bus.cmd_rdy & ~bus.error;
  assign err_frame = bus.cmd_rdy & bus.error;
  assign wr_clr    = bus.kbsr_wr & bus.kbsr_wdata[13];

  // Parity bit, KBSR read strobe and read-only write bits have no effect here.
  logic unused_bits;
  assign unused_bits = ^{bus.cmd[8], bus.kbsr_rd, bus.kbsr_wdata[15], bus.kbsr_wdata[12:0]};

  // Prefix FSM: next state and event push request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d       = state_q;
    push_req      = 1'b0;
    push_evt.brk  = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    push_evt.ext  = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    push_evt.code = scan;
    if (err_frame) begin
      state_d = S_IDLE;
    end else if (ok_frame) begin
      if (scan == CODE_EXT) begin
        state_d = S_EXT;
      end else if (scan == CODE_BRK) begin
        unique case (state_q)
          S_IDLE:  state_d = S_BRK;
          S_EXT:   state_d = S_EXT_BRK;
          default: state_d = state_q;
        endcase
      end else begin
        push_req = 1'b1;
        state_d  = S_IDLE;
      end
    end
  end

  // FIFO bookkeeping, status fields and next values of the output registers.
  always_comb begin
    pop      = bus.kbdr_rd && (count_q != '0);
    full     = (count_q == FULL_CNT);
    push_ok  = push_req && (!full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;

    ie_d = bus.kbsr_wr ? bus.kbsr_wdata[14] : ie_q;

    ovf_d = ovf_q;
    if (wr_clr)                      ovf_d = 1'b0;
    else if (push_req && full && !pop) ovf_d = 1'b1;

    errcnt_d = errcnt_q;
    if (wr_clr)                               errcnt_d = '0;
    else if (err_frame && errcnt_q != 8'hFF)  errcnt_d = errcnt_q + 8'd1;

    // A push into the slot that becomes the head must bypass the array.
    head_d = (push_ok && wr_ptr_q == rd_ptr_d) ? push_evt : mem_q[rd_ptr_d];
    kbdr_d = (count_d != '0) ? {6'b0, head_d} : 16'h0000;
    kbsr_d = {(count_d != '0), ie_d, ovf_d, 1'b0, 4'(count_d), errcnt_d};
    irq_d  = ie_d && (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ie_q     <= 1'b0;
      ovf_q    <= 1'b0;
      errcnt_q <= '0;
      kbsr_q   <= '0;
      kbdr_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ie_q     <= ie_d;
      ovf_q    <= ovf_d;
      errcnt_q <= errcnt_d;
      kbsr_q   <= kbsr_d;
      kbdr_q   <= kbdr_d;
      irq_q    <= irq_d;
    end
  end

  // NOTE: the event array is not reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_evt;
  end

  assign bus.kbsr    = kbsr_q;
  assign bus.kbdr    = kbdr_q;
  assign bus.kbd_irq = irq_q;

endmodule
